// File: rtl/fpga_buttons.sv
// fpga_buttons: memory-mapped button/switch input port with debounce and
// sticky write-1-to-clear edge flags, on the fpga_* sel/we/ready bus.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   btn_sel, we       peripheral select, write enable
//   btn_addr          0 LEVEL (RO), 1 RISE (W1C), 2 FALL (W1C), 3 IRQ_EN
//   btn_data_i/_o     32-bit write / read data (low BTN_COUNT bits used)
//   btn_ready         = btn_sel (zero wait states)
//   btn_pins          raw asynchronous pins
//   irq               level interrupt
//
// Optional feature: define FPGA_BUTTONS_IRQ_EN to implement the IRQ_EN
// register and the registered irq output; otherwise irq is tied to 0
// and address 3 reads 0.

module fpga_buttons #(
    parameter int BTN_COUNT       = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_sel,
    input  logic [1:0]           btn_addr,
    input  logic [31:0]          btn_data_i,
    input  logic                 we,
    output logic                 btn_ready,
    output logic [31:0]          btn_data_o,
    input  logic [BTN_COUNT-1:0] btn_pins,
    output logic                 irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [BTN_COUNT-1:0] pressed;
    logic [BTN_COUNT-1:0] sync1;
    logic [BTN_COUNT-1:0] sync2;
    logic [BTN_COUNT-1:0] stable;
    logic [BTN_COUNT-1:0] stable_d;
    logic [BTN_COUNT-1:0] rise;
    logic [BTN_COUNT-1:0] fall;
    logic [BTN_COUNT-1:0] rise_clr;
    logic [BTN_COUNT-1:0] fall_clr;
    logic [BTN_COUNT-1:0] irq_en_rd;
    logic [CW-1:0]        cnt_q [BTN_COUNT];
    logic [CW-1:0]        cnt_d [BTN_COUNT];
    logic                 wr;
    logic                 unused_wdata;

    // Polarity is normalised before the synchroniser so that the
    // reset value 0 of every stage means "released".
    assign pressed = ACTIVE_LOW ? ~btn_pins : btn_pins;

    assign wr        = btn_sel & we;
    assign btn_ready = btn_sel;

    // Upper write-data bits are don't-care.
    assign unused_wdata = ^btn_data_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pressed;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: the counter only runs while the synchronised
    // input disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        stable_d = stable;
        for (int i = 0; i < BTN_COUNT; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise_clr = (wr && btn_addr == 2'd1) ?
                      btn_data_i[BTN_COUNT-1:0] : '0;
    assign fall_clr = (wr && btn_addr == 2'd2) ?
                      btn_data_i[BTN_COUNT-1:0] : '0;

    // Set terms are OR-ed after the clear so a same-edge set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            rise   <= '0;
            fall   <= '0;
            for (int i = 0; i < BTN_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable <= stable_d;
            rise   <= (rise & ~rise_clr) | (stable_d & ~stable);
            fall   <= (fall & ~fall_clr) | (~stable_d & stable);
            for (int i = 0; i < BTN_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef FPGA_BUTTONS_IRQ_EN
    logic [BTN_COUNT-1:0] irq_en;
    logic                 irq_q;

    // irq looks at the registered flags, so it trails a flag
    // change by one edge in both directions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr && btn_addr == 2'd3) begin
                irq_en <= btn_data_i[BTN_COUNT-1:0];
            end
            irq_q <= |((rise | fall) & irq_en);
        end
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = '0;
`endif

    always_comb begin
        btn_data_o = '0;
        if (btn_sel) begin
            case (btn_addr)
                2'd0:    btn_data_o[BTN_COUNT-1:0] = stable;
                2'd1:    btn_data_o[BTN_COUNT-1:0] = rise;
                2'd2:    btn_data_o[BTN_COUNT-1:0] = fall;
                default: btn_data_o[BTN_COUNT-1:0] = irq_en_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_buttons.sv
// tb_fpga_buttons: directed bench for fpga_buttons
// (BTN_COUNT=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4).

module tb_fpga_buttons;

`ifdef FPGA_BUTTONS_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        btn_sel;
    logic [1:0]  btn_addr;
    logic [31:0] btn_data_i;
    logic        we;
    logic        btn_ready;
    logic [31:0] btn_data_o;
    logic [3:0]  btn_pins;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    fpga_buttons #(
        .BTN_COUNT      (4),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_sel   (btn_sel),
        .btn_addr  (btn_addr),
        .btn_data_i(btn_data_i),
        .we        (we),
        .btn_ready (btn_ready),
        .btn_data_o(btn_data_o),
        .btn_pins  (btn_pins),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_rd(input string tag,
                          input logic [1:0] a,
                          input logic [31:0] exp);
        btn_sel  = 1'b1;
        we       = 1'b0;
        btn_addr = a;
        #1;
        chk(tag, btn_data_o, exp);
    endtask

    // Write occupies exactly one active edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        btn_sel    = 1'b1;
        we         = 1'b1;
        btn_addr   = a;
        btn_data_i = d;
        tick();
        we         = 1'b0;
        btn_data_i = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_sel    = 1'b0;
        btn_addr   = 2'd0;
        btn_data_i = '0;
        we         = 1'b0;
        btn_pins   = 4'hF;
        ticks(2);

        // Reset state
        #1;
        chk("rst_ready0", {31'd0, btn_ready}, 32'd0);
        chk("rst_unsel_data", btn_data_o, 32'd0);
        btn_sel = 1'b1;
        #1;
        chk("rst_ready1", {31'd0, btn_ready}, 32'd1);
        for (int a = 0; a < 4; a++) begin
            chk_rd($sformatf("rst_addr%0d", a), 2'(a), 32'd0);
        end
        chk("rst_irq", {31'd0, irq}, 32'd0);

        tick();
        reset_n = 1'b1;
        ticks(3);
        chk_rd("idle_level", 2'd0, 32'd0);

        // Press pin0: accepted on the 6th edge
        btn_pins = 4'hE;
        ticks(5);
        chk_rd("press_level_e5", 2'd0, 32'd0);
        tick();
        chk_rd("press_level_e6", 2'd0, 32'd1);
        chk_rd("press_rise", 2'd1, 32'd1);
        chk_rd("press_fall", 2'd2, 32'd0);

        btn_pins = 4'hF;
        ticks(6);
        chk_rd("release_level", 2'd0, 32'd0);
        chk_rd("release_fall", 2'd2, 32'd1);
        chk_rd("release_rise", 2'd1, 32'd1);
        wr(2'd1, 32'hF);
        wr(2'd2, 32'hF);
        chk_rd("clr_rise", 2'd1, 32'd0);
        chk_rd("clr_fall", 2'd2, 32'd0);

        // Glitch of 3 cycles is rejected
        btn_pins = 4'hE;
        ticks(3);
        btn_pins = 4'hF;
        ticks(8);
        chk_rd("glitch_level", 2'd0, 32'd0);
        chk_rd("glitch_rise", 2'd1, 32'd0);
        chk_rd("glitch_fall", 2'd2, 32'd0);

        // W1C race: set of rise[1] and clear of rise[1:0] on one edge
        btn_pins = 4'hE;
        ticks(6);
        chk_rd("race_rise0", 2'd1, 32'd1);
        btn_pins = 4'hC;
        ticks(5);
        chk_rd("race_pre_level", 2'd0, 32'd1);
        wr(2'd1, 32'h3);
        chk_rd("race_rise", 2'd1, 32'h2);
        chk_rd("race_level", 2'd0, 32'h3);
        wr(2'd0, 32'h0);
        chk_rd("ro_level", 2'd0, 32'h3);
        btn_pins = 4'hF;
        ticks(6);
        chk_rd("race_rel_level", 2'd0, 32'd0);
        chk_rd("race_rel_fall", 2'd2, 32'h3);
        wr(2'd1, 32'hF);
        wr(2'd2, 32'hF);
        chk_rd("race_clr_rise", 2'd1, 32'd0);
        chk_rd("race_clr_fall", 2'd2, 32'd0);

        // IRQ enable and timing
        wr(2'd3, 32'h1);
        chk_rd("irq_en_rd", 2'd3, IRQ_ON ? 32'h1 : 32'h0);
        btn_pins = 4'hE;
        ticks(6);
        chk_rd("irq_rise", 2'd1, 32'd1);
        chk("irq_pre", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        wr(2'd1, 32'h1);
        chk_rd("irq_rise_clr", 2'd1, 32'd0);
        chk("irq_clr_edge", {31'd0, irq}, {31'd0, IRQ_ON});
        tick();
        chk("irq_clr_next", {31'd0, irq}, 32'd0);
        btn_pins = 4'hF;
        ticks(6);
        chk_rd("irq_fall", 2'd2, 32'd1);
        wr(2'd2, 32'h1);
        chk("irq_fall_set", {31'd0, irq}, {31'd0, IRQ_ON});
        tick();
        chk("irq_fall_clr", {31'd0, irq}, 32'd0);
        wr(2'd3, 32'h0);
        chk_rd("irq_en_off", 2'd3, 32'd0);

        // Reset in the middle of a debounce count
        btn_pins = 4'hE;
        ticks(4);
        reset_n = 1'b0;
        #1;
        chk_rd("mid_rst_level", 2'd0, 32'd0);
        chk_rd("mid_rst_rise", 2'd1, 32'd0);
        ticks(2);
        reset_n = 1'b1;
        ticks(5);
        chk_rd("post_rst_e5", 2'd0, 32'd0);
        tick();
        chk_rd("post_rst_level", 2'd0, 32'd1);
        chk_rd("post_rst_rise", 2'd1, 32'd1);
        btn_sel = 1'b0;
        #1;
        chk("unsel_data", btn_data_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
